// File: rtl/sawtooth_pkg.sv
// Shared constants and state encoding for the sawtooth counter front panel.
package sawtooth_pkg;

    localparam int unsigned DATA_W_DEFAULT    = 8;
    localparam int unsigned DEB_TICKS_DEFAULT = 2;
    // Debounce counter width, enough for DEB_TICKS up to 15.
    localparam int unsigned CNT_W             = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_N1 = 2'd1,
        PAIR   = 2'd2
    } entry_state_t;

endpackage

// File: rtl/button_entry_rx_if.sv
// N1/N2 pair handshake between the button receiver and the sawtooth FSM.
interface button_entry_rx_if
    import sawtooth_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic [DATA_W-1:0] n1_o;
    logic [DATA_W-1:0] n2_o;
    logic              pair_valid_o;
    logic              pair_ready_i;

    modport master (
        output n1_o,
        output n2_o,
        output pair_valid_o,
        input  pair_ready_i
    );

    modport slave (
        input  n1_o,
        input  n2_o,
        input  pair_valid_o,
        output pair_ready_i
    );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, tick-sampled debounce, press pulse.
module btn_debounce
    import sawtooth_pkg::*;
#(
    parameter int unsigned DEB_TICKS = DEB_TICKS_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic btn_ni,
    output logic press_o
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_accept;

    // New level accepted on the DEB_TICKS-th consecutive differing tick sample.
    assign w_accept = tick_i && (r_sync2 != r_level) && (r_cnt == CNT_W'(DEB_TICKS - 1));

    // Synchroniser, debounce counter and press pulse (accepted level 1->0).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= btn_ni;
            r_sync2 <= r_sync1;
            r_press <= w_accept && !r_sync2;
            if (tick_i) begin
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign press_o = r_press;

endmodule

// File: rtl/button_entry_rx.sv
// Front-panel receiver: collects N1/N2 from V presses, emits ST start strobes.
module button_entry_rx
    import sawtooth_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned DEB_TICKS = DEB_TICKS_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tick_i,
    input  logic                     v_ni,
    input  logic                     st_ni,
    input  logic [DATA_W-1:0]        din_i,
    button_entry_rx_if.master        pair_if,
    output logic                     start_o,
    output logic [1:0]               entry_state_o,
    output logic                     drop_o
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_GOT_N1 = GOT_N1;
    localparam logic [1:0] S_PAIR   = PAIR;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_n1;
    logic [DATA_W-1:0] r_n2;
    logic              r_valid;
    logic              r_start;
    logic              r_drop;

    logic              w_v_press;
    logic              w_st_press;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_n1_nxt;
    logic [DATA_W-1:0] w_n2_nxt;
    logic              w_drop_nxt;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_v (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tick_i  (tick_i),
        .btn_ni  (v_ni),
        .press_o (w_v_press)
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_st (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tick_i  (tick_i),
        .btn_ni  (st_ni),
        .press_o (w_st_press)
    );

    // State and output registers; valid tracks the PAIR state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_n1    <= '0;
            r_n2    <= '0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n1    <= w_n1_nxt;
            r_n2    <= w_n2_nxt;
            r_valid <= (w_state_nxt == S_PAIR);
            r_start <= w_st_press;
            r_drop  <= w_drop_nxt;
        end
    end

    // Entry sequencing: capture N1, then N2, then hold the pair until taken.
    always_comb begin
        w_state_nxt = r_state;
        w_n1_nxt    = r_n1;
        w_n2_nxt    = r_n2;
        w_drop_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_v_press) begin
                    w_n1_nxt    = din_i;
                    w_state_nxt = S_GOT_N1;
                end
            end
            S_GOT_N1: begin
                if (w_v_press) begin
                    w_n2_nxt    = din_i;
                    w_state_nxt = S_PAIR;
                end
            end
            S_PAIR: begin
                w_drop_nxt = w_v_press;
                if (r_valid && pair_if.pair_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pair_if.n1_o         = r_n1;
    assign pair_if.n2_o         = r_n2;
    assign pair_if.pair_valid_o = r_valid;
    assign start_o              = r_start;
    assign drop_o               = r_drop;
    assign entry_state_o        = r_state;

endmodule

// File: tb/tb_button_entry_rx.sv
// Self-checking bench for button_entry_rx with a press-level reference model.
module tb_button_entry_rx;

    localparam int unsigned DW  = 8;
    localparam int          DEB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic [1:0]    tdiv = 2'd0;
    logic          v_n = 1'b1;
    logic          st_n = 1'b1;
    logic [DW-1:0] din = '0;
    logic          start;
    logic          drop;
    logic [1:0]    est;

    button_entry_rx_if #(.DATA_W(DW)) pif ();

    button_entry_rx #(.DATA_W(DW), .DEB_TICKS(DEB)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tick_i        (tick),
        .v_ni          (v_n),
        .st_ni         (st_n),
        .din_i         (din),
        .pair_if       (pif),
        .start_o       (start),
        .entry_state_o (est),
        .drop_o        (drop)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clocks.
    always @(posedge clk) begin
        tdiv <= tdiv + 2'd1;
        tick <= (tdiv == 2'd3);
    end

    int errors = 0;
    int checks = 0;

    // Pulse/transfer counters observed mid-cycle.
    int start_cnt = 0;
    int drop_cnt  = 0;
    int xfer_cnt  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (start) start_cnt++;
            if (drop) drop_cnt++;
            if (pif.pair_valid_o && pif.pair_ready_i) xfer_cnt++;
        end
    end

    // Reference model at the level of accepted button presses.
    int            m_state = 0;
    logic [DW-1:0] m_n1 = '0;
    logic [DW-1:0] m_n2 = '0;
    int            m_start = 0;
    int            m_drop = 0;
    int            m_xfer = 0;

    task automatic model_v(input logic [DW-1:0] d);
        if (m_state == 0) begin
            m_n1 = d; m_state = 1;
        end else if (m_state == 1) begin
            m_n2 = d; m_state = 2;
        end else begin
            m_drop++;
        end
        if (m_state == 2 && pif.pair_ready_i) begin
            m_state = 0; m_xfer++;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_n1 = '0; m_n2 = '0;
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (tick !== 1'b1) @(posedge clk);
        #1;
    endtask

    // Hold the selected buttons low for 'hold' tick samples, then release.
    task automatic press(input bit use_v, input bit use_st, input logic [DW-1:0] d, input int hold);
        wait_tick();
        din = d;
        if (use_v) v_n = 1'b0;
        if (use_st) st_n = 1'b0;
        repeat (hold) wait_tick();
        v_n = 1'b1;
        st_n = 1'b1;
        repeat (3) wait_tick();
        if (hold >= DEB) begin
            if (use_v) model_v(d);
            if (use_st) m_start++;
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        pif.pair_ready_i = r;
        repeat (2) @(posedge clk);
        #1;
        if (r && m_state == 2) begin
            m_state = 0; m_xfer++;
        end
    endtask

    task automatic test_reset();
        v_n = 1'b0; st_n = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; v_n = 1'b1; st_n = 1'b1;
        model_reset();
        checks++; if (pif.n1_o !== 8'd0) begin errors++; $display("FAIL reset_n1 got=%0d exp=0", pif.n1_o); end
        checks++; if (pif.n2_o !== 8'd0) begin errors++; $display("FAIL reset_n2 got=%0d exp=0", pif.n2_o); end
        checks++; if (pif.pair_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", pif.pair_valid_o); end
        checks++; if (est !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", est); end
        checks++; if (start !== 1'b0 || drop !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%0b%0b exp=00", start, drop); end
        repeat (6) wait_tick();
        checks++; if (start_cnt !== 0 || drop_cnt !== 0) begin errors++; $display("FAIL reset_quiet got=%0d/%0d exp=0/0", start_cnt, drop_cnt); end
        checks++; if (est !== 2'd0) begin errors++; $display("FAIL reset_quiet_state got=%0d exp=0", est); end
    endtask

    task automatic test_pair_entry();
        press(1'b1, 1'b0, 8'd20, 3);
        checks++; if (est !== 2'(m_state)) begin errors++; $display("FAIL pair_got_n1 got=%0d exp=%0d", est, m_state); end
        press(1'b1, 1'b0, 8'd40, 2);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (pif.n1_o !== m_n1) begin errors++; $display("FAIL pair_n1 got=%0d exp=%0d", pif.n1_o, m_n1); end
        checks++; if (pif.n2_o !== m_n2) begin errors++; $display("FAIL pair_n2 got=%0d exp=%0d", pif.n2_o, m_n2); end
        checks++; if (pif.pair_valid_o !== 1'b1 || est !== 2'd2) begin errors++; $display("FAIL pair_held got=%0b/%0d exp=1/2", pif.pair_valid_o, est); end
        @(posedge clk); #1;
        pif.pair_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (pif.pair_valid_o !== 1'b0 || est !== 2'd0) begin errors++; $display("FAIL pair_xfer got=%0b/%0d exp=0/0", pif.pair_valid_o, est); end
        m_state = 0; m_xfer++;
        pif.pair_ready_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (pif.n1_o !== 8'd20 || pif.n2_o !== 8'd40) begin errors++; $display("FAIL pair_hold_after got=%0d/%0d exp=20/40", pif.n1_o, pif.n2_o); end
        checks++; if (xfer_cnt !== m_xfer) begin errors++; $display("FAIL pair_xfer_count got=%0d exp=%0d", xfer_cnt, m_xfer); end
    endtask

    task automatic test_debounce();
        press(1'b1, 1'b0, 8'd99, 1);
        checks++; if (est !== 2'd0) begin errors++; $display("FAIL deb_glitch_state got=%0d exp=0", est); end
        checks++; if (pif.n1_o !== 8'd20) begin errors++; $display("FAIL deb_glitch_n1 got=%0d exp=20", pif.n1_o); end
        press(1'b1, 1'b0, 8'd20, 20);
        checks++; if (est !== 2'(m_state) || est !== 2'd1) begin errors++; $display("FAIL deb_long_state got=%0d exp=%0d", est, m_state); end
        checks++; if (pif.n1_o !== m_n1) begin errors++; $display("FAIL deb_long_n1 got=%0d exp=%0d", pif.n1_o, m_n1); end
    endtask

    task automatic test_drop();
        press(1'b1, 1'b0, 8'd40, 2);
        press(1'b1, 1'b0, 8'd76, 2);
        checks++; if (drop_cnt !== m_drop || m_drop !== 1) begin errors++; $display("FAIL drop_count got=%0d exp=%0d", drop_cnt, m_drop); end
        checks++; if (pif.n1_o !== 8'd20 || pif.n2_o !== 8'd40) begin errors++; $display("FAIL drop_data got=%0d/%0d exp=20/40", pif.n1_o, pif.n2_o); end
        checks++; if (pif.pair_valid_o !== 1'b1) begin errors++; $display("FAIL drop_valid got=%0b exp=1", pif.pair_valid_o); end
        set_ready(1'b1);
        set_ready(1'b0);
        checks++; if (est !== 2'd0) begin errors++; $display("FAIL drop_cleared got=%0d exp=0", est); end
    endtask

    task automatic test_start();
        bit         seen;
        logic [1:0] prev;
        press(1'b0, 1'b1, 8'd0, 2);
        checks++; if (start_cnt !== m_start) begin errors++; $display("FAIL start_idle got=%0d exp=%0d", start_cnt, m_start); end
        press(1'b1, 1'b0, 8'd7, 2);
        press(1'b0, 1'b1, 8'd7, 2);
        checks++; if (start_cnt !== m_start || est !== 2'd1) begin errors++; $display("FAIL start_got_n1 got=%0d/%0d exp=%0d/1", start_cnt, est, m_start); end
        seen = 1'b0;
        prev = est;
        fork
            press(1'b1, 1'b1, 8'd9, 2);
            begin
                for (int i = 0; i < 300 && !seen; i++) begin
                    @(negedge clk);
                    if (start === 1'b1) begin
                        seen = 1'b1;
                        checks++;
                        if (pif.n2_o !== 8'd9 || est !== 2'd2 || prev !== 2'd1) begin
                            errors++; $display("FAIL start_simul got=n2 %0d st %0d prev %0d exp=9/2/1", pif.n2_o, est, prev);
                        end
                    end
                    prev = est;
                end
            end
        join
        checks++; if (!seen) begin errors++; $display("FAIL start_simul_timeout got=none exp=pulse"); end
        press(1'b0, 1'b1, 8'd0, 2);
        checks++; if (start_cnt !== m_start || m_start !== 4) begin errors++; $display("FAIL start_pair got=%0d exp=%0d", start_cnt, m_start); end
        checks++; if (pif.n1_o !== 8'd7 || pif.pair_valid_o !== 1'b1) begin errors++; $display("FAIL start_pair_data got=%0d/%0b exp=7/1", pif.n1_o, pif.pair_valid_o); end
        set_ready(1'b1);
        set_ready(1'b0);
    endtask

    task automatic test_mid_reset();
        press(1'b1, 1'b0, 8'd15, 2);
        checks++; if (pif.n1_o !== 8'd15 || est !== 2'd1) begin errors++; $display("FAIL mid_n1 got=%0d/%0d exp=15/1", pif.n1_o, est); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++; if (pif.n1_o !== 8'd0 || est !== 2'd0 || pif.pair_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset got=%0d/%0d/%0b exp=0/0/0", pif.n1_o, est, pif.pair_valid_o); end
        press(1'b1, 1'b0, 8'd15, 2);
        press(1'b1, 1'b0, 8'd76, 2);
        checks++; if (pif.n1_o !== m_n1 || pif.n2_o !== m_n2) begin errors++; $display("FAIL mid_pair got=%0d/%0d exp=%0d/%0d", pif.n1_o, pif.n2_o, m_n1, m_n2); end
        checks++; if (pif.pair_valid_o !== 1'b1) begin errors++; $display("FAIL mid_valid got=%0b exp=1", pif.pair_valid_o); end
        set_ready(1'b1);
        set_ready(1'b0);
    endtask

    task automatic test_random();
        int            kind;
        int            hold;
        logic [DW-1:0] d;
        for (int it = 0; it < 16; it++) begin
            set_ready(1'($urandom_range(0, 1)));
            kind = int'($urandom_range(0, 2));
            hold = int'($urandom_range(1, 4));
            d    = DW'($urandom);
            press(kind != 1, kind != 0, d, hold);
            checks++; if (est !== 2'(m_state)) begin errors++; $display("FAIL rand_state it=%0d got=%0d exp=%0d", it, est, m_state); end
            checks++; if (pif.n1_o !== m_n1 || pif.n2_o !== m_n2) begin errors++; $display("FAIL rand_data it=%0d got=%0d/%0d exp=%0d/%0d", it, pif.n1_o, pif.n2_o, m_n1, m_n2); end
            checks++; if (pif.pair_valid_o !== (m_state == 2)) begin errors++; $display("FAIL rand_valid it=%0d got=%0b exp=%0b", it, pif.pair_valid_o, m_state == 2); end
            checks++; if (start_cnt !== m_start || drop_cnt !== m_drop) begin errors++; $display("FAIL rand_pulses it=%0d got=%0d/%0d exp=%0d/%0d", it, start_cnt, drop_cnt, m_start, m_drop); end
        end
        checks++; if (xfer_cnt !== m_xfer) begin errors++; $display("FAIL rand_xfer got=%0d exp=%0d", xfer_cnt, m_xfer); end
    endtask

    initial begin
        pif.pair_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_pair_entry();
        test_debounce();
        test_drop();
        test_start();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
